// File: rtl/vmem_port_arbiter.sv
// Arbitrates the single data-memory port between the scalar load/store path and the
// vector memory unit: round-robin in idle, exclusive vector ownership, burst watchdog.
module vmem_port_arbiter #(
   parameter int unsigned TMO_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_s_re,
   input  logic        i_s_we,
   input  logic [31:0] i_s_addr,
   input  logic [31:0] i_s_wdata,
   output logic [31:0] o_s_rdata,
   output logic        o_s_stall,
   input  logic        i_v_req,
   output logic        o_v_gnt,
   input  logic        i_v_done,
   input  logic        i_v_re,
   input  logic        i_v_we,
   input  logic [31:0] i_v_addr,
   input  logic [31:0] i_v_wdata,
   output logic [31:0] o_v_rdata,
   output logic        o_v_abort,
   output logic        o_mem_re,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   output logic [1:0]  o_owner,
   output logic        o_err,
   input  logic        i_err_clr
);

   localparam int unsigned CntW = $clog2(TMO_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TMO_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StVGrant = 2'd1,
      StVOwn   = 2'd2,
      StVRel   = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic            last_v_q, last_v_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;

   logic s_req;
   logic s_served;
   logic timeout;
   logic vec_own;

   assign s_req   = i_s_re | i_s_we;
   assign vec_own = (state_q == StVGrant) || (state_q == StVOwn);

   always_comb begin
      state_d  = state_q;
      last_v_d = last_v_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      s_served = 1'b0;
      timeout  = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            // Scalar wins unless the vector side is owed the next turn.
            if (s_req && (!i_v_req || last_v_q)) begin
               s_served = 1'b1;
               last_v_d = 1'b0;
            end else if (i_v_req) begin
               state_d  = StVGrant;
               last_v_d = 1'b1;
            end
         end
         StVGrant: begin
            cnt_d   = cnt_q + CntW'(1);
            state_d = i_v_done ? StVRel : StVOwn;
         end
         StVOwn: begin
            cnt_d = cnt_q + CntW'(1);
            if (i_v_done) begin
               state_d = StVRel;
            end else if (cnt_q == CntLast) begin
               timeout = 1'b1;
               state_d = StVRel;
            end
         end
         StVRel: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (timeout) begin
         err_d = 1'b1;
      end else if (i_err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         last_v_q <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_v_q <= last_v_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // Outputs are forced low while reset is held so nothing leaks onto the port.
   always_comb begin
      o_owner     = 2'd0;
      o_v_gnt     = 1'b0;
      o_v_abort   = 1'b0;
      o_err       = 1'b0;
      o_s_stall   = 1'b0;
      o_mem_re    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = 32'd0;
      o_mem_wdata = 32'd0;
      o_s_rdata   = 32'd0;
      o_v_rdata   = 32'd0;
      if (!rst) begin
         o_owner   = state_q;
         o_v_gnt   = (state_q == StVGrant);
         o_v_abort = timeout;
         o_err     = err_q;
         o_s_stall = s_req & ~s_served;
         if (vec_own) begin
            o_mem_re    = i_v_re;
            o_mem_we    = i_v_we;
            o_mem_addr  = i_v_addr;
            o_mem_wdata = i_v_wdata;
            o_v_rdata   = i_mem_rdata;
         end else if (s_served) begin
            o_mem_re    = i_s_re;
            o_mem_we    = i_s_we;
            o_mem_addr  = i_s_addr;
            o_mem_wdata = i_s_wdata;
            o_s_rdata   = i_mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Randomized bench for vmem_port_arbiter against a cycle-level reference model that
// tracks port ownership as "cycles since grant" plus a release flag.
module tb_vmem_port_arbiter;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_s_re, i_s_we, i_v_req, i_v_done, i_v_re, i_v_we, i_err_clr;
   logic [31:0] i_s_addr, i_s_wdata, i_v_addr, i_v_wdata, i_mem_rdata;
   logic [31:0] o_s_rdata, o_v_rdata, o_mem_addr, o_mem_wdata;
   logic        o_s_stall, o_v_gnt, o_v_abort, o_mem_re, o_mem_we, o_err;
   logic [1:0]  o_owner;

   int checks = 0;
   int failures = 0;

   // Reference state: m_held = cycles since grant (-1 when vector does not own the port).
   int m_held;
   bit m_rel, m_last_v, m_err;
   logic [135:0] exp_vec, act_vec;

   always #5 clk = ~clk;

   vmem_port_arbiter #(.TMO_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .i_s_re(i_s_re), .i_s_we(i_s_we), .i_s_addr(i_s_addr), .i_s_wdata(i_s_wdata),
      .o_s_rdata(o_s_rdata), .o_s_stall(o_s_stall),
      .i_v_req(i_v_req), .o_v_gnt(o_v_gnt), .i_v_done(i_v_done),
      .i_v_re(i_v_re), .i_v_we(i_v_we), .i_v_addr(i_v_addr), .i_v_wdata(i_v_wdata),
      .o_v_rdata(o_v_rdata), .o_v_abort(o_v_abort),
      .o_mem_re(o_mem_re), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
      .o_owner(o_owner), .o_err(o_err), .i_err_clr(i_err_clr)
   );

   assign act_vec = {o_owner, o_v_gnt, o_v_abort, o_s_stall, o_err, o_mem_re, o_mem_we,
                     o_mem_addr, o_mem_wdata, o_s_rdata, o_v_rdata};

   task automatic model_reset();
      m_held   = -1;
      m_rel    = 1'b0;
      m_last_v = 1'b0;
      m_err    = 1'b0;
   endtask

   // Computes this cycle's expected outputs from the current inputs, then advances.
   task automatic model_eval();
      logic [1:0]  owner;
      logic        gnt, abort, stall, mre, mwe, served, vwin, sreq;
      logic [31:0] maddr, mwd, srd, vrd;
      owner = 0; gnt = 0; abort = 0; mre = 0; mwe = 0;
      maddr = 0; mwd = 0; srd = 0; vrd = 0; served = 0; vwin = 0;
      sreq  = i_s_re | i_s_we;
      stall = sreq;
      if (m_rel) begin
         owner = 3;
      end else if (m_held >= 0) begin
         owner = (m_held == 0) ? 2'd1 : 2'd2;
         gnt   = (m_held == 0);
         abort = (m_held == TMO - 1) && !i_v_done;
         mre = i_v_re; mwe = i_v_we; maddr = i_v_addr; mwd = i_v_wdata; vrd = i_mem_rdata;
      end else begin
         served = sreq && (!i_v_req || m_last_v);
         vwin   = i_v_req && !served;
         stall  = sreq && !served;
         if (served) begin
            mre = i_s_re; mwe = i_s_we; maddr = i_s_addr; mwd = i_s_wdata; srd = i_mem_rdata;
         end
      end
      exp_vec = {owner, gnt, abort, stall, m_err, mre, mwe, maddr, mwd, srd, vrd};
      if (abort) m_err = 1'b1;
      else if (i_err_clr) m_err = 1'b0;
      if (m_rel) begin
         m_rel = 1'b0;
      end else if (m_held >= 0) begin
         if (i_v_done || abort) begin
            m_held = -1;
            m_rel  = 1'b1;
         end else begin
            m_held++;
         end
      end else if (served) begin
         m_last_v = 1'b0;
      end else if (vwin) begin
         m_last_v = 1'b1;
         m_held   = 0;
      end
   endtask

   task automatic idle_inputs();
      i_s_re = 0; i_s_we = 0; i_v_req = 0; i_v_done = 0; i_v_re = 0; i_v_we = 0;
      i_err_clr = 0;
      i_s_addr = $urandom; i_s_wdata = $urandom; i_v_addr = $urandom; i_v_wdata = $urandom;
      i_mem_rdata = $urandom;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         i_s_re = 1; i_v_req = 1; i_v_re = 1;
         #2;
         checks++;
         if (act_vec !== 136'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", act_vec);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      rst = 0;
      model_reset();
   endtask

   task automatic test_scalar();
      for (int i = 0; i < 6; i++) begin
         idle_inputs();
         if (i == 0) begin
            i_s_re = 1; i_s_addr = 32'h100; i_mem_rdata = 32'hDEADBEEF;
         end else begin
            {i_s_re, i_s_we} = 2'($urandom_range(1, 3));
         end
         @(negedge clk);
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            failures++;
            $display("FAIL scalar_%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_vector_burst();
      for (int i = 0; i < 8; i++) begin
         idle_inputs();
         i_v_req = (i == 0);
         if (i >= 1 && i <= 5) begin
            i_v_we = 1; i_v_re = (i == 5);
            i_v_addr = 32'h200 + 32'((i - 1) * 4);
         end
         i_v_done = (i == 4);
         @(negedge clk);
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            failures++;
            $display("FAIL vburst_%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_contention();
      for (int i = 0; i < 20; i++) begin
         idle_inputs();
         i_s_re = 1; i_v_req = 1; i_v_re = 1;
         i_v_done = (m_held == 2);
         @(negedge clk);
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            failures++;
            $display("FAIL contention_%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_watchdog();
      // Burst that never finishes, error clear, then a burst finishing on the last cycle.
      for (int i = 0; i < 30; i++) begin
         idle_inputs();
         i_v_req   = (i == 0) || (i == 15);
         i_err_clr = (i == 12);
         i_v_done  = (i > 15) && (m_held == TMO - 1);
         i_s_we    = (i % 3 == 0);
         @(negedge clk);
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            failures++;
            $display("FAIL watchdog_%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      i_v_req = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         model_eval();
         @(posedge clk); #1;
         i_v_req = 0;
      end
      i_v_re = 1; i_s_re = 1;
      #1 rst = 1;
      #1;
      checks++;
      if (act_vec !== 136'd0) begin
         failures++;
         $display("FAIL reset_mid_own got=%h want=0", act_vec);
      end
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         i_s_re = 1;
         @(negedge clk);
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            failures++;
            $display("FAIL post_reset_scalar_%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         idle_inputs();
         i_s_re    = ($urandom_range(0, 2) == 0);
         i_s_we    = ($urandom_range(0, 3) == 0);
         i_v_req   = ($urandom_range(0, 2) == 0);
         i_v_done  = ($urandom_range(0, 9) == 0);
         i_v_re    = $urandom_range(0, 1);
         i_v_we    = $urandom_range(0, 1);
         i_err_clr = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         model_eval();
         checks++;
         if (act_vec !== exp_vec) begin
            failures++;
            $display("FAIL random_%0d got=%h want=%h", i, act_vec, exp_vec);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_scalar();
      test_vector_burst();
      test_contention();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vmem_port_arbiter.md
Name: vmem_port_arbiter

Overview:
- Shares the single 32-bit data-memory port between the scalar load/store path and the vector memory-access unit (the unit that runs unit-stride and strided vector loads/stores).
- Scalar accesses are single-cycle pass-through. A vector transfer is granted exclusive ownership of the port from its start until its done pulse.
- Contention in idle is resolved round-robin. A watchdog aborts vector bursts that never finish.
- Sits between the core and the data memory; it feeds the vector unit's start gating.

Parameters:
TMO_CYCLES, 256, max cycles a vector owner may hold the port (counted from grant) before forced abort; must be >= 2.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
i_s_re  in  1  scalar read request.
i_s_we  in  1  scalar write request.
i_s_addr  in  32  scalar address.
i_s_wdata  in  32  scalar write data.
o_s_rdata  out  32  scalar read data.
o_s_stall  out  1  scalar request not served this cycle; hold request.
i_v_req  in  1  vector memory op pending; level, held until o_v_gnt.
o_v_gnt  out  1  one-cycle grant; vector unit may launch its op.
i_v_done  in  1  vector unit done pulse.
i_v_re  in  1  vector read enable.
i_v_we  in  1  vector write enable.
i_v_addr  in  32  vector address.
i_v_wdata  in  32  vector write data.
o_v_rdata  out  32  vector read data.
o_v_abort  out  1  one-cycle watchdog abort to vector unit.
o_mem_re  out  1  memory read enable.
o_mem_we  out  1  memory write enable.
o_mem_addr  out  32  memory address.
o_mem_wdata  out  32  memory write data.
i_mem_rdata  in  32  memory read data, combinational (valid in same cycle as o_mem_re).
o_owner  out  2  0 = idle/scalar, 1 = vector grant, 2 = vector own, 3 = release.
o_err  out  1  sticky watchdog error.
i_err_clr  in  1  clears o_err.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; r_last_v=0, watchdog count=0, o_err=0.
  - All outputs are 0.
  - Reset during a vector burst returns to IDLE immediately with no o_v_abort pulse.
- States: IDLE(0), VGRANT(1), VOWN(2), VREL(3). o_owner = state encoding.
- IDLE, let s_req = i_s_re | i_s_we:
  - s_req only: scalar drives memory this cycle; o_s_stall=0; r_last_v<=0.
  - i_v_req only: next state VGRANT; r_last_v<=1; no memory access this cycle.
  - Both, r_last_v=1: scalar served this cycle; vector waits.
  - Both, r_last_v=0: vector wins (next VGRANT); o_s_stall=1; memory idle.
- VGRANT: o_v_gnt=1 (Moore, exactly one cycle).
  - i_v_done=1 -> VREL.
  - Otherwise -> VOWN.
- VOWN:
  - i_v_done=1 -> VREL.
  - Watchdog reaches TMO_CYCLES-1 without done -> o_v_abort=1 that cycle, o_err<=1, next VREL.
- VREL: one bus-turnaround cycle; memory idle; -> IDLE.
- Memory mux:
  - In VGRANT/VOWN: o_mem_* = vector inputs; o_v_rdata = i_mem_rdata.
  - When scalar is served in IDLE: o_mem_* = scalar inputs; o_s_rdata = i_mem_rdata.
  - Otherwise all o_mem_* = 0 and both rdata outputs = 0.
- o_s_stall = s_req & not-served:
  - Always 1 in VGRANT, VOWN and VREL when s_req=1.
  - 0 when s_req=0.
- Watchdog: count cleared in IDLE/VREL; increments each cycle in VGRANT/VOWN; width $clog2(TMO_CYCLES+1). Done on the same cycle as timeout: done wins, no abort, no error.
- o_err stays set until i_err_clr=1 (cleared next edge). Set and clear in the same cycle: set wins.
- i_v_done outside VGRANT/VOWN is ignored.
- i_s_re and i_s_we both 1: both forwarded unchanged; no arbitration change.

Test Plan:
1. Scalar read only, i_s_addr=0x100, i_mem_rdata=0xDEADBEEF -> same cycle o_mem_re=1, o_mem_addr=0x100, o_s_rdata=0xDEADBEEF, o_s_stall=0, o_owner=0.
2. i_v_req alone -> next cycle o_v_gnt=1 for exactly 1 cycle. Vector writes 4 words at 0x200,0x204,... pass through. i_v_done -> one VREL cycle with o_mem_we=0, then IDLE.
3. Scalar and vector request together from reset (r_last_v=0) -> vector granted, scalar stalled through VREL, scalar served the first IDLE cycle. Repeat contention -> scalar wins, confirming alternation.
4. TMO_CYCLES=8, vector never asserts done -> o_v_abort pulses on 8th owned cycle, o_err=1 sticky, VREL then IDLE. i_err_clr -> o_err=0. Done on cycle 8 instead -> no abort.
5. Assert rst mid-VOWN -> outputs immediately 0, o_owner=0, no o_v_abort. After release, scalar access is served normally.
